// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential unsigned restoring divider. Computes
//               Q = floor(A/B) and R = A mod B over W iterations, one
//               shift-and-subtract step per clock, using a (W+1)-bit
//               ripple-carry subtractor for the trial subtraction.
//               Divide-by-zero is answered immediately with Q = all ones,
//               R = A and dbz = 1.
// Ports       : clk    - rising-edge clock
//               rst_n  - synchronous, active-low reset
//               start  - request pulse, sampled only while idle
//               A, B   - dividend / divisor, sampled on the accepting edge
//               busy   - high while iterating
//               done   - one-cycle pulse; Q, R, dbz valid from here on
//               Q, R   - quotient / remainder
//               dbz    - divide-by-zero flag of the last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         dbz
);

    localparam int            CW     = $clog2(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next;

    // Quotient shift register: holds the dividend at start, the quotient
    // bits shift in from the right as the dividend bits shift out the left.
    logic [W-1:0]  r_q;
    // Partial remainder. After every restoring step its top bit is zero,
    // so only the low W bits are kept.
    logic [W-1:0]  r_p;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;

    logic [W:0]    w_ps;      // {P,Q} shifted left: new P, W+1 bits wide
    logic [W:0]    w_nb;      // one's complement of {0,B}
    logic [W:0]    w_t;       // trial difference P_shifted - {0,B}
    logic          w_b_zero;
    logic          w_last;

    assign w_ps     = {r_p, r_q[W-1]};
    assign w_nb     = ~{1'b0, r_b};
    assign w_b_zero = (B == '0);
    assign w_last   = (r_cnt == C_LAST);

    // Ripple-carry adder in subtract mode: P_shifted + ~{0,B} + 1.
    // A negative result shows up as w_t[W] = 1.
    always_comb begin : p_ripple_sub
        logic carry;
        w_t   = '0;
        carry = 1'b1;
        for (int i = 0; i <= W; i++) begin
            w_t[i] = w_ps[i] ^ w_nb[i] ^ carry;
            carry  = (w_ps[i] & w_nb[i]) | (carry & (w_ps[i] ^ w_nb[i]));
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_CALC:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_p   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_b_zero) begin
                            // Answered without iterating.
                            r_q   <= '1;
                            r_p   <= A;
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= A;
                            r_b   <= B;
                            r_p   <= '0;
                            r_cnt <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_t[W]) begin
                        r_p <= w_t[W-1:0];
                        r_q <= {r_q[W-2:0], 1'b1};
                    end else begin
                        // Restore: keep the shifted remainder.
                        r_p <= w_ps[W-1:0];
                        r_q <= {r_q[W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q   = r_q;
    assign R   = r_p;
    assign dbz = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Instantiates a W=16 and
//               a W=8 divider, applies a directed vector table, hand-written
//               corner sequences (ignored start, reset mid-operation) and a
//               random sweep checked against plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        rst_n;

    logic        start16, busy16, done16, dbz16;
    logic [15:0] a16, b16, q16, r16;

    logic        start8, busy8, done8, dbz8;
    logic [7:0]  a8, b8, q8, r8;

    int n_tests;
    int n_fail;

    seq_divider #(.W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .A     (a16),
        .B     (b16),
        .busy  (busy16),
        .done  (done16),
        .Q     (q16),
        .R     (r16),
        .dbz   (dbz16)
    );

    seq_divider #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .busy  (busy8),
        .done  (done8),
        .Q     (q8),
        .R     (r8),
        .dbz   (dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs [6];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done16;
    endfunction

    // One complete operation with exact timing checks: done must appear
    // W edges after the accepting edge (0 for B=0), busy for exactly W
    // cycles (0 for B=0), never together with done, and done lasts 1 cycle.
    task automatic do_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q_exp, input logic [31:0] r_exp,
                         input logic dbz_exp, input string tag);
        int          w;
        int          lat;
        int          nbusy;
        int          ovl;
        logic [31:0] qv;
        logic [31:0] rv;
        logic        dv;
        w = w8 ? 8 : 16;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0];
        end
        @(posedge clk);
        #1;
        if (w8) start8 = 1'b0; else start16 = 1'b0;
        lat   = -1;
        nbusy = 0;
        ovl   = 0;
        qv    = '0;
        rv    = '0;
        dv    = 1'b0;
        for (int k = 0; k <= w + 2 && lat < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (get_busy(w8)) nbusy++;
            if (get_busy(w8) && get_done(w8)) ovl = 1;
            if (get_done(w8)) begin
                lat = k;
                qv  = w8 ? {24'd0, q8} : {16'd0, q16};
                rv  = w8 ? {24'd0, r8} : {16'd0, r16};
                dv  = w8 ? dbz8 : dbz16;
            end
        end
        check({tag, ".latency"}, lat, (b == 0) ? 0 : w);
        check({tag, ".busy_cycles"}, nbusy, (b == 0) ? 0 : w);
        check({tag, ".busy_done_overlap"}, ovl, 0);
        check({tag, ".Q"}, qv, q_exp);
        check({tag, ".R"}, rv, r_exp);
        check({tag, ".dbz"}, {31'd0, dv}, {31'd0, dbz_exp});
        @(posedge clk);
        #1;
        check({tag, ".done_single"}, {31'd0, get_done(w8)}, 0);
    endtask

    // Reference model: plain integer division.
    task automatic rand_op(input bit w8, input int idx);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mask;
        mask = w8 ? 32'hFF : 32'hFFFF;
        a = $urandom & mask;
        b = $urandom & mask;
        if ($urandom_range(0, 15) == 0) b = 0;
        else if ($urandom_range(0, 7) == 0) b = $urandom_range(1, 3);
        if ($urandom_range(0, 7) == 0) a = mask;
        if (b == 0)
            do_op(w8, a, b, mask, a, 1'b1,
                  $sformatf("rand%0d_%0d", w8 ? 8 : 16, idx));
        else
            do_op(w8, a, b, a / b, a % b, 1'b0,
                  $sformatf("rand%0d_%0d", w8 ? 8 : 16, idx));
    endtask

    initial begin
        int          first;
        int          nd;
        logic [15:0] qc;
        logic [15:0] rc;

        n_tests = 0;
        n_fail  = 0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; a8  = '0; b8  = '0;
        rst_n   = 1'b0;

        vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,     r: 16'd2,     dbz: 1'b0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,   r: 16'd0,     dbz: 1'b0};
        vecs[2] = '{a: 16'd5,     b: 16'd9,      q: 16'd0,      r: 16'd5,     dbz: 1'b0};
        vecs[3] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,      r: 16'd0,     dbz: 1'b0};
        vecs[4] = '{a: 16'h04D2,  b: 16'd0,      q: 16'hFFFF,   r: 16'h04D2,  dbz: 1'b1};
        vecs[5] = '{a: 16'd10,    b: 16'd3,      q: 16'd3,      r: 16'd1,     dbz: 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy16", {31'd0, busy16}, 0);
        check("reset.done16", {31'd0, done16}, 0);
        check("reset.Q16", {16'd0, q16}, 0);
        check("reset.R16", {16'd0, r16}, 0);
        check("reset.dbz16", {31'd0, dbz16}, 0);
        check("reset.QR8", {16'd0, q8, r8}, 0);
        check("reset.flags8", {29'd0, busy8, done8, dbz8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i])
            do_op(1'b0, {16'd0, vecs[i].a}, {16'd0, vecs[i].b},
                  {16'd0, vecs[i].q}, {16'd0, vecs[i].r}, vecs[i].dbz,
                  $sformatf("vec%0d", i));

        // Results hold after done
        repeat (5) @(posedge clk);
        #1;
        check("hold.Q", {16'd0, q16}, 3);
        check("hold.R", {16'd0, r16}, 1);
        check("hold.dbz", {31'd0, dbz16}, 0);

        // Start during CALC is ignored
        @(negedge clk);
        start16 = 1'b1; a16 = 16'd100; b16 = 16'd7;
        @(posedge clk);                  // E0
        #1;
        start16 = 1'b0;
        repeat (4) @(posedge clk);       // E4
        @(negedge clk);
        start16 = 1'b1; a16 = 16'd9; b16 = 16'd3;
        @(posedge clk);                  // E5
        #1;
        start16 = 1'b0;
        first = -1;
        nd    = 0;
        qc    = '0;
        rc    = '0;
        for (int k = 6; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                nd++;
                if (first < 0) begin
                    first = k;
                    qc    = q16;
                    rc    = r16;
                end
            end
        end
        check("ignore.done_edge", first, 16);
        check("ignore.done_count", nd, 1);
        check("ignore.Q", {16'd0, qc}, 14);
        check("ignore.R", {16'd0, rc}, 2);

        // Reset in the middle of an operation
        @(negedge clk);
        start16 = 1'b1; a16 = 16'd1000; b16 = 16'd10;
        @(posedge clk);                  // E0
        #1;
        start16 = 1'b0;
        repeat (7) @(posedge clk);       // E7
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);                  // E8
        #1;
        rst_n = 1'b1;
        check("midrst.busy", {31'd0, busy16}, 0);
        check("midrst.done", {31'd0, done16}, 0);
        check("midrst.QR", {q16, r16}, 0);
        check("midrst.dbz", {31'd0, dbz16}, 0);
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done16 || busy16) nd++;
        end
        check("midrst.no_activity", nd, 0);
        do_op(1'b0, 50, 6, 8, 2, 1'b0, "after_rst");

        // Random sweep on both widths in parallel
        fork
            begin
                for (int i = 0; i < 2000; i++) rand_op(1'b0, i);
            end
            begin
                for (int j = 0; j < 3000; j++) rand_op(1'b1, j);
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
